// File: rtl/wave_display_pkg.sv
// Shared constants and types for the waveform display read path.
package wave_display_pkg;

  // Screen window geometry: 256 samples at 2 px each, 256 rows of amplitude.
  localparam int WIN_W       = 512;
  localparam int WIN_H       = 256;

  // Cycles from x/y presented to r/g/b valid (RAM read + output register).
  localparam int PIX_LATENCY = 2;

  localparam logic [23:0] TRACE_RGB_DEF = 24'hFFFFFF;
  localparam logic [23:0] GRID_RGB_DEF  = 24'h303030;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/wave_trace_pipe.sv
// Two-stage alignment of window decode with RAM read data, plus the
// current/previous sample tracking and the lit decision for the trace.
module wave_trace_pipe (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] addr,
  input  logic       in_win,
  input  logic [7:0] y_off,
  input  logic       first_col,
  input  logic       valid,
  input  logic [7:0] read_value,
  output logic       valid_q,
  output logic       lit_q
);

  logic [8:0] addr_s1, addr_s2;
  logic       in_win_s1, first_s1, valid_s1;
  logic [7:0] y_off_s1;
  logic [7:0] cur_s, prev_s;
  logic [7:0] cur_n, prev_n;
  logic [7:0] top_prev, top_cur, span_lo, span_hi;
  logic       lit_n;

  // Stage 1: hold the decode of the pixel whose RAM data arrives this cycle.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order blocks are evaluated in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_s1   <= '0;
      in_win_s1 <= 1'b0;
      y_off_s1  <= '0;
      first_s1  <= 1'b0;
      valid_s1  <= 1'b0;
    end else begin
      addr_s1   <= addr;
      in_win_s1 <= in_win;
      y_off_s1  <= y_off;
      first_s1  <= first_col;
      valid_s1  <= valid;
    end
  end

  // Advance the sample pair on a new address; the first column seeds both
  // samples with the same value so no segment is drawn from the previous row.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    cur_n  = cur_s;
    prev_n = prev_s;
    if (first_s1) begin
      cur_n  = read_value;
      prev_n = read_value;
    end else if (addr_s1 != addr_s2) begin
      cur_n  = read_value;
      prev_n = cur_s;
    end
    // Sample 0 is at the bottom row, so row offset = 255 - sample.
    top_prev = 8'd255 - prev_n;
    top_cur  = 8'd255 - cur_n;
    span_lo  = (top_prev < top_cur) ? top_prev : top_cur;
    span_hi  = (top_prev < top_cur) ? top_cur  : top_prev;
    lit_n    = in_win_s1 && (y_off_s1 >= span_lo) && (y_off_s1 <= span_hi);
  end

  // Stage 2: registered sample pair and pixel result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_s2 <= '0;
      cur_s   <= '0;
      prev_s  <= '0;
      valid_q <= 1'b0;
      lit_q   <= 1'b0;
    end else begin
      addr_s2 <= addr_s1;
      cur_s   <= cur_n;
      prev_s  <= prev_n;
      valid_q <= valid_s1;
      lit_q   <= lit_n;
    end
  end

endmodule

// File: rtl/wave_display.sv
// Read side of the double-buffered waveform RAM: maps scan coordinates to
// RAM addresses and renders the selected half-buffer as a connected trace.
// Optional background grid is enabled by defining WAVE_DISPLAY_GRID_EN.
module wave_display
  import wave_display_pkg::*;
#(
  parameter logic [10:0] X_START   = 11'd128,
  parameter logic [9:0]  Y_START   = 10'd256,
  parameter logic [23:0] TRACE_RGB = TRACE_RGB_DEF
`ifdef WAVE_DISPLAY_GRID_EN
  , parameter logic [23:0] GRID_RGB = GRID_RGB_DEF
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  input  logic        valid,
  input  logic        read_index,
  input  logic [7:0]  read_value,
  output logic [8:0]  read_address,
  output logic        valid_pixel,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        wave_display_idle
);

  localparam logic [11:0] X_END = {1'b0, X_START} + 12'(WIN_W);
  localparam logic [10:0] Y_END = {1'b0, Y_START} + 11'(WIN_H);

  logic [8:0] x_off;
  logic [7:0] y_off, sample_idx;
  logic       in_rows, in_win, first_col;
  logic       rd_idx_q, idle_q;
  logic       valid_q, lit_q;
  rgb_t       pix;

  // Window decode; offsets only need the bits inside the window.
  assign x_off      = 9'(x - X_START);
  assign y_off      = 8'(y - Y_START);
  assign in_rows    = (y >= Y_START) && ({1'b0, y} < Y_END);
  assign in_win     = valid && in_rows && (x >= X_START) && ({1'b0, x} < X_END);
  assign sample_idx = in_win ? x_off[8:1] : 8'd0;
  assign first_col  = in_win && (x_off == 9'd0);

  assign read_address = {rd_idx_q, sample_idx};

  // Buffer select only follows read_index between frames, so a swap can
  // never tear the trace mid-window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q   <= 1'b0;
      rd_idx_q <= 1'b0;
    end else begin
      idle_q <= valid && !in_rows;
      if (idle_q) rd_idx_q <= read_index;
    end
  end

  wave_trace_pipe u_trace (
    .clk        (clk),
    .reset      (reset),
    .addr       (read_address),
    .in_win     (in_win),
    .y_off      (y_off),
    .first_col  (first_col),
    .valid      (valid),
    .read_value (read_value),
    .valid_q    (valid_q),
    .lit_q      (lit_q)
  );

`ifdef WAVE_DISPLAY_GRID_EN
  logic grid_c, grid_s1, grid_s2;
  assign grid_c = in_win && ((x_off[4:0] == 5'd0) || (y_off[4:0] == 5'd0));

  // Delay the grid flag to line up with the trace pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grid_s1 <= 1'b0;
      grid_s2 <= 1'b0;
    end else begin
      grid_s1 <= grid_c;
      grid_s2 <= grid_s1;
    end
  end
`endif

  // Colour select from registered flags; the trace wins over the grid.
  always_comb begin
    pix = '0;
    if (lit_q) pix = TRACE_RGB;
`ifdef WAVE_DISPLAY_GRID_EN
    else if (grid_s2) pix = GRID_RGB;
`endif
  end

  assign r                 = pix.r;
  assign g                 = pix.g;
  assign b                 = pix.b;
  assign valid_pixel       = valid_q;
  assign wave_display_idle = idle_q;

endmodule
